// File: rtl/plab4_net_router_input_term_ctrl_adapt_if.sv
// Injection-side handshake bundle between the input queue / output arbiters
// and the input-terminal route control of one ring router.
interface plab4_net_router_input_term_ctrl_adapt_if #(
   parameter int p_dest_nbits = 3,
   parameter int p_free_nbits = 2
);
   logic [p_dest_nbits-1:0] dest;
   logic                    in_val;
   logic                    in_rdy;
   logic [p_free_nbits-1:0] num_free_west;
   logic [p_free_nbits-1:0] num_free_east;
   logic [2:0]              reqs;
   logic [2:0]              grants;

   modport master (
      output dest, in_val, num_free_west, num_free_east, grants,
      input  in_rdy, reqs
   );

   modport slave (
      input  dest, in_val, num_free_west, num_free_east, grants,
      output in_rdy, reqs
   );
endinterface

// File: rtl/plab4_net_router_input_term_ctrl_adapt.sv
// Ring-router input-terminal control: shortest-path routing, bubble credit gate,
// direction hold. Define PLAB4_NET_ROUTER_CONG_TIEBREAK_EN for congestion-aware ties.
module plab4_net_router_input_term_ctrl_adapt #(
   parameter int  p_router_id      = 0,
   parameter int  p_num_routers    = 8,
   parameter int  p_num_free_nbits = 2,
   parameter int  p_bubble         = 2,
   parameter int  p_cong_nbits     = 3,
   localparam int c_dest_nbits     = $clog2(p_num_routers)
) (
   input logic clk,
   input logic reset,
   plab4_net_router_input_term_ctrl_adapt_if.slave io
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
   typedef enum logic [1:0] {D_WEST = 2'd0, D_TERM = 2'd1, D_EAST = 2'd2} dir_e;

   localparam logic [c_dest_nbits:0]   c_id  = (c_dest_nbits+1)'(p_router_id);
   localparam logic [c_dest_nbits:0]   c_n   = (c_dest_nbits+1)'(p_num_routers);
   localparam logic [p_cong_nbits-1:0] c_one = (p_cong_nbits)'(1);

   state_e state_q, state_d;
   dir_e   hold_dir_q, hold_dir_d;
   logic   hold_tie_q, hold_tie_d;
   logic   tb_q, tb_d;

   dir_e   fresh_dir, cur_dir;
   logic   fresh_tie, cur_tie;
   logic   credit_w, credit_e;
   logic   in_rdy, xfer;
   logic [2:0] reqs;
   logic [p_cong_nbits-1:0]     cong_w, cong_e;
   logic [p_num_free_nbits-1:0] free_w, free_e;
   logic [c_dest_nbits:0]       dest_x, dist_w, dist_e;

   // One extra bit keeps dest + N from wrapping for any ring size.
   assign dest_x = {1'b0, io.dest};
   assign dist_w = (dest_x >= c_id) ? dest_x - c_id : dest_x + c_n - c_id;
   assign dist_e = (c_id >= dest_x) ? c_id - dest_x : c_id + c_n - dest_x;

   assign free_w   = io.num_free_west;
   assign free_e   = io.num_free_east;
   assign credit_w = int'(free_w) >= p_bubble;
   assign credit_e = int'(free_e) >= p_bubble;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      fresh_tie = 1'b0;
      fresh_dir = D_TERM;
      if (dest_x == c_id) begin
         fresh_dir = D_TERM;
      end else if (dist_w < dist_e) begin
         fresh_dir = D_WEST;
      end else if (dist_w > dist_e) begin
         fresh_dir = D_EAST;
      end else begin
         fresh_tie = 1'b1;
         if (cong_w < cong_e)      fresh_dir = D_WEST;
         else if (cong_e < cong_w) fresh_dir = D_EAST;
         else                      fresh_dir = tb_q ? D_EAST : D_WEST;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_dir_d = hold_dir_q;
      hold_tie_d = hold_tie_q;
      tb_d       = tb_q;
      cur_dir    = (state_q == S_WAIT) ? hold_dir_q : fresh_dir;
      cur_tie    = (state_q == S_WAIT) ? hold_tie_q : fresh_tie;
      reqs       = 3'b000;

      if (!reset && io.in_val) begin
         unique case (cur_dir)
            D_WEST:  reqs[2] = credit_w;
            D_TERM:  reqs[1] = 1'b1;
            D_EAST:  reqs[0] = credit_e;
            default: reqs    = 3'b000;
         endcase
      end

      in_rdy = |(reqs & io.grants);
      xfer   = io.in_val && in_rdy;

      unique case (state_q)
         S_IDLE: if (io.in_val && !xfer) begin
            state_d    = S_WAIT;
            hold_dir_d = fresh_dir;
            hold_tie_d = fresh_tie;
         end
         S_WAIT: if (xfer || !io.in_val) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (xfer && cur_tie) tb_d = !tb_q;
   end

   assign io.reqs   = reqs;
   assign io.in_rdy = in_rdy;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         hold_dir_q <= D_WEST;
         hold_tie_q <= 1'b0;
         tb_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_dir_q <= hold_dir_d;
         hold_tie_q <= hold_tie_d;
         tb_q       <= tb_d;
      end
   end

`ifdef PLAB4_NET_ROUTER_CONG_TIEBREAK_EN
   logic [p_cong_nbits-1:0] cong_w_q, cong_e_q;

   // A granted ring request relieves its counter; a stalled one charges it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cong_w_q <= '0;
         cong_e_q <= '0;
      end else if (io.in_val) begin
         if (cur_dir == D_WEST) begin
            if (in_rdy) begin
               if (cong_w_q != '0) cong_w_q <= cong_w_q - c_one;
            end else if (cong_w_q != '1) begin
               cong_w_q <= cong_w_q + c_one;
            end
         end else if (cur_dir == D_EAST) begin
            if (in_rdy) begin
               if (cong_e_q != '0) cong_e_q <= cong_e_q - c_one;
            end else if (cong_e_q != '1) begin
               cong_e_q <= cong_e_q + c_one;
            end
         end
      end
   end

   assign cong_w = cong_w_q;
   assign cong_e = cong_e_q;
`else
   assign cong_w = '0;
   assign cong_e = '0;
`endif

endmodule

// File: tb/tb_plab4_net_router_input_term_ctrl_adapt.sv
// Directed bench: ring of 8 (id 2) for routing, credit, hold, tie and reset;
// ring of 5 (id 4) for non-power-of-two distances.
module tb_plab4_net_router_input_term_ctrl_adapt;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   plab4_net_router_input_term_ctrl_adapt_if #(.p_dest_nbits(3), .p_free_nbits(2)) bus8 ();
   plab4_net_router_input_term_ctrl_adapt_if #(.p_dest_nbits(3), .p_free_nbits(2)) bus5 ();

   plab4_net_router_input_term_ctrl_adapt #(
      .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2), .p_bubble(2), .p_cong_nbits(3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus8)
   );

   plab4_net_router_input_term_ctrl_adapt #(
      .p_router_id(4), .p_num_routers(5), .p_num_free_nbits(2), .p_bubble(2), .p_cong_nbits(3)
   ) dut5 (
      .clk   (clk),
      .reset (reset),
      .io    (bus5)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive8(input logic rst, input logic [2:0] dest, input logic val,
                         input logic [1:0] fw, input logic [1:0] fe, input logic [2:0] g);
      @(negedge clk);
      reset              = rst;
      bus8.dest          = dest;
      bus8.in_val        = val;
      bus8.num_free_west = fw;
      bus8.num_free_east = fe;
      bus8.grants        = g;
      #1;
   endtask

   task automatic exp8(input string tag, input logic [2:0] r, input logic rdy);
      check({tag, ".reqs"}, {29'd0, bus8.reqs}, {29'd0, r});
      check({tag, ".rdy"}, {31'd0, bus8.in_rdy}, {31'd0, rdy});
   endtask

   task automatic step5(input string tag, input logic [2:0] dest, input logic [2:0] r);
      @(negedge clk);
      bus5.dest   = dest;
      bus5.in_val = 1'b1;
      bus5.grants = 3'b111;
      #1;
      check({tag, ".reqs"}, {29'd0, bus5.reqs}, {29'd0, r});
      check({tag, ".rdy"}, {31'd0, bus5.in_rdy}, 32'd1);
   endtask

   initial begin
      reset              = 1'b1;
      bus8.dest          = '0;
      bus8.in_val        = 1'b0;
      bus8.num_free_west = '0;
      bus8.num_free_east = '0;
      bus8.grants        = '0;
      bus5.dest          = '0;
      bus5.in_val        = 1'b0;
      bus5.num_free_west = 2'd3;
      bus5.num_free_east = 2'd3;
      bus5.grants        = '0;

      // Reset masks requests even with every input active
      drive8(1'b1, 3'd4, 1'b1, 2'd3, 2'd3, 3'b111);  exp8("reset_mask", 3'b000, 1'b0);

      // Terminal, then shortest path west and east
      drive8(1'b0, 3'd2, 1'b1, 2'd3, 2'd3, 3'b010);  exp8("terminal", 3'b010, 1'b1);
      drive8(1'b0, 3'd4, 1'b1, 2'd3, 2'd3, 3'b100);  exp8("west", 3'b100, 1'b1);
      check("idle_after_term", {31'd0, dut.state_q}, 32'd0);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("east", 3'b001, 1'b1);

      // Grant on a non-requested bit is ignored
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b110);  exp8("stray_grant", 3'b001, 1'b0);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("east_held_xfer", 3'b001, 1'b1);

      // Bubble on west: one free slot blocks, two lets it through
      drive8(1'b0, 3'd4, 1'b1, 2'd1, 2'd3, 3'b100);  exp8("bubble_block", 3'b000, 1'b0);
      drive8(1'b0, 3'd4, 1'b1, 2'd2, 2'd3, 3'b100);
      check("wait_on_bubble", {31'd0, dut.state_q}, 32'd1);
      exp8("bubble_pass", 3'b100, 1'b1);

      // Hold: destination changes while waiting do not re-route
      drive8(1'b0, 3'd4, 1'b1, 2'd3, 2'd3, 3'b000);  exp8("hold_0", 3'b100, 1'b0);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b000);  exp8("hold_1", 3'b100, 1'b0);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("hold_2", 3'b100, 1'b0);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b100);  exp8("hold_xfer", 3'b100, 1'b1);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("after_hold", 3'b001, 1'b1);

      // Reset while waiting discards the held direction
      drive8(1'b0, 3'd4, 1'b1, 2'd3, 2'd3, 3'b000);  exp8("pre_reset_wait", 3'b100, 1'b0);
      drive8(1'b1, 3'd4, 1'b1, 2'd3, 2'd3, 3'b100);  exp8("reset_in_wait", 3'b000, 1'b0);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("fresh_after_reset", 3'b001, 1'b1);

      // Ties at distance 4 alternate; a held tie also toggles on transfer
      drive8(1'b0, 3'd6, 1'b1, 2'd3, 2'd3, 3'b100);  exp8("tie_0", 3'b100, 1'b1);
      drive8(1'b0, 3'd6, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("tie_1", 3'b001, 1'b1);
      drive8(1'b0, 3'd6, 1'b1, 2'd3, 2'd3, 3'b000);  exp8("tie_hold_0", 3'b100, 1'b0);
      drive8(1'b0, 3'd6, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("tie_hold_1", 3'b100, 1'b0);
      drive8(1'b0, 3'd6, 1'b1, 2'd3, 2'd3, 3'b100);  exp8("tie_hold_xfer", 3'b100, 1'b1);
      drive8(1'b0, 3'd6, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("tie_2", 3'b001, 1'b1);

      // Bubble on east
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd1, 3'b001);  exp8("bubble_e_block", 3'b000, 1'b0);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd2, 3'b001);  exp8("bubble_e_pass", 3'b001, 1'b1);

      // Dropping in_val while waiting returns to a fresh decision
      drive8(1'b0, 3'd4, 1'b1, 2'd3, 2'd3, 3'b000);  exp8("drop_wait", 3'b100, 1'b0);
      drive8(1'b0, 3'd4, 1'b0, 2'd3, 2'd3, 3'b000);
      drive8(1'b0, 3'd0, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("after_drop", 3'b001, 1'b1);

`ifdef PLAB4_NET_ROUTER_CONG_TIEBREAK_EN
      // West congested far above east: a tie goes east although tb favours west
      drive8(1'b0, 3'd4, 1'b1, 2'd0, 2'd3, 3'b100);
      drive8(1'b0, 3'd4, 1'b1, 2'd0, 2'd3, 3'b100);
      drive8(1'b0, 3'd4, 1'b1, 2'd0, 2'd3, 3'b100);
      drive8(1'b0, 3'd4, 1'b0, 2'd3, 2'd3, 3'b000);
      drive8(1'b0, 3'd6, 1'b1, 2'd3, 2'd3, 3'b001);  exp8("cong_tie", 3'b001, 1'b1);
`endif

      drive8(1'b0, 3'd0, 1'b0, 2'd3, 2'd3, 3'b000);

      // Ring of 5, id 4
      step5("n5_dest0", 3'd0, 3'b100);
      step5("n5_dest1", 3'd1, 3'b100);
      step5("n5_dest2", 3'd2, 3'b001);
      step5("n5_dest3", 3'd3, 3'b001);
      step5("n5_dest4", 3'd4, 3'b010);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
